// File: rtl/vend_dp_gen_if.sv
// Bus bundle between the vending datapath and its environment:
// command/keypad/coin-acceptor inputs, hopper handshake and status outputs.
interface vend_dp_gen_if #(
  parameter int N_ITEMS = 4,
  parameter int MONEY_W = 16
);
  logic [1:0]         in_cmd;
  logic [N_ITEMS-1:0] in_sel;
  logic               in_inserted_5;
  logic               in_inserted_1;
  logic               in_inserted_05;
  logic               in_inserted_025;
  logic               in_coin_ready;

  logic [N_ITEMS-1:0] out_stock;
  logic [N_ITEMS-1:0] out_csel;
  logic [N_ITEMS-1:0] out_spit;
  logic [MONEY_W-1:0] out_credit;
  logic [MONEY_W-1:0] out_total;
  logic               out_sol_ok;
  logic               out_coin_valid;
  logic [1:0]         out_coin_type;
  logic               out_busy;
  logic               out_err;

  // Environment side: FSM, keypad, coin acceptor and hopper
  modport master (
    output in_cmd, in_sel, in_inserted_5, in_inserted_1, in_inserted_05,
           in_inserted_025, in_coin_ready,
    input  out_stock, out_csel, out_spit, out_credit, out_total, out_sol_ok,
           out_coin_valid, out_coin_type, out_busy, out_err
  );

  // Datapath side
  modport slave (
    input  in_cmd, in_sel, in_inserted_5, in_inserted_1, in_inserted_05,
           in_inserted_025, in_coin_ready,
    output out_stock, out_csel, out_spit, out_credit, out_total, out_sol_ok,
           out_coin_valid, out_coin_type, out_busy, out_err
  );
endinterface

// File: rtl/vend_dp_gen.sv
// Vending datapath: item selection, credit and coin inventory, greedy exact
// change planning ($1/$0.50/$0.25) and coin-by-coin payout to the hopper.
// Money is counted in quarters. All flops update on the falling clock edge.
module vend_dp_gen #(
  parameter int                          N_ITEMS    = 4,
  parameter int                          MONEY_W    = 16,
  parameter int                          CNT_W      = 8,
  parameter logic [N_ITEMS*MONEY_W-1:0]  PRICE_LIST = {16'd14, 16'd12, 16'd10, 16'd8},
  parameter logic [N_ITEMS*CNT_W-1:0]    INIT_STOCK = {8'd1, 8'd4, 8'd4, 8'd4},
  parameter logic [CNT_W-1:0]            INIT_C1    = 8'd2,
  parameter logic [CNT_W-1:0]            INIT_C05   = 8'd2,
  parameter logic [CNT_W-1:0]            INIT_C025  = 8'd0
) (
  input  logic          in_clka,
  input  logic          in_restart,
  vend_dp_gen_if.slave  bus
);

  localparam logic [1:0] CMD_SITEM  = 2'b00;
  localparam logic [1:0] CMD_SMONEY = 2'b01;
  localparam logic [1:0] CMD_CLEAR  = 2'b10;
  localparam logic [1:0] CMD_START  = 2'b11;

  localparam logic [1:0] COIN_1   = 2'b00;
  localparam logic [1:0] COIN_05  = 2'b01;
  localparam logic [1:0] COIN_025 = 2'b10;

  localparam logic [MONEY_W:0]   INS_5_W   = (MONEY_W+1)'(5'd20);
  localparam logic [MONEY_W:0]   INS_1_W   = (MONEY_W+1)'(3'd4);
  localparam logic [MONEY_W:0]   INS_05_W  = (MONEY_W+1)'(2'd2);
  localparam logic [MONEY_W:0]   INS_025_W = (MONEY_W+1)'(1'd1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [MONEY_W-1:0] MONEY_ZERO = {MONEY_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_PAYOUT = 2'd2
  } state_t;

  typedef struct packed {
    logic             ok;
    logic [CNT_W-1:0] n1;
    logic [CNT_W-1:0] n05;
    logic [CNT_W-1:0] n025;
  } plan_t;

  // Greedy change: as many $1 as possible, then $0.50, then $0.25, each
  // limited by the coins actually held; ok when nothing is left over.
  function automatic plan_t greedy_plan(input logic [MONEY_W-1:0] x,
                                        input logic [CNT_W-1:0]   c1,
                                        input logic [CNT_W-1:0]   c05,
                                        input logic [CNT_W-1:0]   c025);
    logic [MONEY_W-1:0] rem;
    logic [MONEY_W-1:0] quo;
    logic [MONEY_W-1:0] lim;
    logic [MONEY_W-1:0] n1_w;
    logic [MONEY_W-1:0] n05_w;
    logic [MONEY_W-1:0] n025_w;
    plan_t              p;
    quo    = x >> 2'd2;
    lim    = MONEY_W'(c1);
    n1_w   = (quo < lim) ? quo : lim;
    rem    = x - (n1_w << 2'd2);
    quo    = rem >> 2'd1;
    lim    = MONEY_W'(c05);
    n05_w  = (quo < lim) ? quo : lim;
    rem    = rem - (n05_w << 2'd1);
    lim    = MONEY_W'(c025);
    n025_w = (rem < lim) ? rem : lim;
    rem    = rem - n025_w;
    p.ok   = (rem == MONEY_ZERO);
    p.n1   = CNT_W'(n1_w);
    p.n05  = CNT_W'(n05_w);
    p.n025 = CNT_W'(n025_w);
    return p;
  endfunction

  // Coin counters stick at full scale instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  state_t             state_r, state_n;
  logic [CNT_W-1:0]   stock_r [N_ITEMS];
  logic [N_ITEMS-1:0] csel_r;
  logic [N_ITEMS-1:0] spit_r;
  logic [MONEY_W-1:0] credit_r;
  logic [CNT_W-1:0]   c1_r, c05_r, c025_r;
  logic [CNT_W-1:0]   n1_r, n05_r, n025_r;
  logic               err_r;

  logic               clear_s;
  logic [MONEY_W-1:0] total_s;
  plan_t              plan_s;
  logic               sol_ok_s;
  logic [MONEY_W:0]   ins_s;
  logic [MONEY_W:0]   sum_s;
  logic               pending_s;
  logic               one_left_s;
  logic [CNT_W+1:0]   left_sum_s;
  logic [1:0]         coin_type_s;
  logic [MONEY_W-1:0] coin_val_s;
  logic               do_start_s, do_vend_s, do_drop_s, latch_plan_s, accept_s, set_err_s;

  assign clear_s = (bus.in_cmd == CMD_CLEAR);

  // Price total of the confirmed selection
  always_comb begin
    total_s = MONEY_ZERO;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (csel_r[i]) begin
        total_s = total_s + PRICE_LIST[i*MONEY_W +: MONEY_W];
      end else begin
        total_s = total_s;
      end
    end
  end

  // Change plan for the current credit; in VEND the selection is already
  // cleared, so the same plan is the payout plan latched into PAYOUT
  always_comb begin
    plan_s   = greedy_plan(credit_r - total_s, c1_r, c05_r, c025_r);
    sol_ok_s = (credit_r >= total_s) && plan_s.ok;
  end

  // Value inserted this cycle and overflow-checked new credit
  always_comb begin
    ins_s = (bus.in_inserted_5   ? INS_5_W   : {(MONEY_W+1){1'b0}})
          + (bus.in_inserted_1   ? INS_1_W   : {(MONEY_W+1){1'b0}})
          + (bus.in_inserted_05  ? INS_05_W  : {(MONEY_W+1){1'b0}})
          + (bus.in_inserted_025 ? INS_025_W : {(MONEY_W+1){1'b0}});
    sum_s = {1'b0, credit_r} + ins_s;
  end

  // Coin currently offered: largest denomination still left in the plan
  always_comb begin
    pending_s  = (n1_r != CNT_ZERO) || (n05_r != CNT_ZERO) || (n025_r != CNT_ZERO);
    left_sum_s = {2'b00, n1_r} + {2'b00, n05_r} + {2'b00, n025_r};
    one_left_s = (left_sum_s == (CNT_W+2)'(1'b1));
    if (n1_r != CNT_ZERO) begin
      coin_type_s = COIN_1;
      coin_val_s  = MONEY_W'(3'd4);
    end else if (n05_r != CNT_ZERO) begin
      coin_type_s = COIN_05;
      coin_val_s  = MONEY_W'(2'd2);
    end else if (n025_r != CNT_ZERO) begin
      coin_type_s = COIN_025;
      coin_val_s  = MONEY_W'(1'd1);
    end else begin
      coin_type_s = COIN_1;
      coin_val_s  = MONEY_ZERO;
    end
  end

  // Next state and datapath actions for this cycle
  always_comb begin
    state_n      = state_r;
    do_start_s   = 1'b0;
    do_vend_s    = 1'b0;
    do_drop_s    = 1'b0;
    latch_plan_s = 1'b0;
    accept_s     = 1'b0;
    set_err_s    = 1'b0;
    if (clear_s) begin
      state_n = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          case (bus.in_cmd)
            CMD_START: do_start_s = 1'b1;
            CMD_SITEM: begin
              if (sol_ok_s && (total_s != MONEY_ZERO)) begin
                do_vend_s = 1'b1;
              end else begin
                do_vend_s = 1'b0;
              end
            end
            CMD_SMONEY: begin
              state_n = ST_VEND;
              if (sol_ok_s) begin
                do_vend_s = 1'b1;
              end else begin
                do_drop_s = 1'b1;
              end
            end
            default: state_n = ST_IDLE;
          endcase
        end
        ST_VEND: begin
          state_n      = ST_PAYOUT;
          latch_plan_s = 1'b1;
        end
        ST_PAYOUT: begin
          if (!pending_s) begin
            state_n   = ST_IDLE;
            set_err_s = (credit_r != MONEY_ZERO);
          end else if (bus.in_coin_ready) begin
            accept_s = 1'b1;
            if (one_left_s) begin
              state_n   = ST_IDLE;
              set_err_s = (credit_r != coin_val_s);
            end else begin
              state_n = ST_PAYOUT;
            end
          end else begin
            state_n = ST_PAYOUT;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(negedge in_clka or posedge in_restart) begin
    if (in_restart) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Credit, selection, stock, coin inventory, payout plan and error flag
  always_ff @(negedge in_clka or posedge in_restart) begin
    if (in_restart) begin
      for (int i = 0; i < N_ITEMS; i++) stock_r[i] <= INIT_STOCK[i*CNT_W +: CNT_W];
      csel_r   <= {N_ITEMS{1'b0}};
      spit_r   <= {N_ITEMS{1'b0}};
      credit_r <= MONEY_ZERO;
      c1_r     <= INIT_C1;
      c05_r    <= INIT_C05;
      c025_r   <= INIT_C025;
      n1_r     <= CNT_ZERO;
      n05_r    <= CNT_ZERO;
      n025_r   <= CNT_ZERO;
      err_r    <= 1'b0;
    end else if (clear_s) begin
      for (int i = 0; i < N_ITEMS; i++) stock_r[i] <= INIT_STOCK[i*CNT_W +: CNT_W];
      csel_r   <= {N_ITEMS{1'b0}};
      spit_r   <= {N_ITEMS{1'b0}};
      credit_r <= MONEY_ZERO;
      c1_r     <= INIT_C1;
      c05_r    <= INIT_C05;
      c025_r   <= INIT_C025;
      n1_r     <= CNT_ZERO;
      n05_r    <= CNT_ZERO;
      n025_r   <= CNT_ZERO;
      err_r    <= 1'b0;
    end else begin
      spit_r <= {N_ITEMS{1'b0}};
      if (do_start_s) begin
        for (int i = 0; i < N_ITEMS; i++) begin
          csel_r[i] <= (csel_r[i] ^ bus.in_sel[i]) && (stock_r[i] != CNT_ZERO);
        end
        // an overflowing insertion is dropped as a whole
        if (!sum_s[MONEY_W]) begin
          credit_r <= sum_s[MONEY_W-1:0];
          if (bus.in_inserted_1)   c1_r   <= sat_inc(c1_r);
          if (bus.in_inserted_05)  c05_r  <= sat_inc(c05_r);
          if (bus.in_inserted_025) c025_r <= sat_inc(c025_r);
        end
      end
      if (do_vend_s) begin
        credit_r <= credit_r - total_s;
        spit_r   <= csel_r;
        csel_r   <= {N_ITEMS{1'b0}};
        for (int i = 0; i < N_ITEMS; i++) begin
          if (csel_r[i]) stock_r[i] <= stock_r[i] - CNT_ONE;
        end
      end
      if (do_drop_s) begin
        csel_r <= {N_ITEMS{1'b0}};
      end
      if (latch_plan_s) begin
        n1_r   <= plan_s.n1;
        n05_r  <= plan_s.n05;
        n025_r <= plan_s.n025;
      end
      if (accept_s) begin
        credit_r <= credit_r - coin_val_s;
        case (coin_type_s)
          COIN_1: begin
            n1_r <= n1_r - CNT_ONE;
            c1_r <= c1_r - CNT_ONE;
          end
          COIN_05: begin
            n05_r <= n05_r - CNT_ONE;
            c05_r <= c05_r - CNT_ONE;
          end
          COIN_025: begin
            n025_r <= n025_r - CNT_ONE;
            c025_r <= c025_r - CNT_ONE;
          end
          default: n1_r <= n1_r;
        endcase
      end
      if (set_err_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Output mapping from the state registers
  always_comb begin
    for (int i = 0; i < N_ITEMS; i++) bus.out_stock[i] = (stock_r[i] != CNT_ZERO);
    bus.out_csel       = csel_r;
    bus.out_spit       = spit_r;
    bus.out_credit     = credit_r;
    bus.out_total      = total_s;
    bus.out_sol_ok     = sol_ok_s;
    bus.out_coin_valid = (state_r == ST_PAYOUT) && pending_s;
    bus.out_coin_type  = coin_type_s;
    bus.out_busy       = (state_r != ST_IDLE);
    bus.out_err        = err_r;
  end

endmodule
